// File: rtl/seq_fsm_4s1i2o_stream_if.sv
// seq_fsm_4s1i2o_stream_if: symbol-in / record-out stream handshake bundle
interface seq_fsm_4s1i2o_stream_if;
  logic       in_val;
  logic       in_rdy;
  logic       in_;
  logic       out_val;
  logic       out_rdy;
  logic       out0;
  logic       out1;
  logic [1:0] state_out;
  logic [7:0] d_count;
  modport master (output in_val, in_, out_rdy,
                  input in_rdy, out_val, out0, out1, state_out, d_count);
  modport slave (input in_val, in_, out_rdy,
                 output in_rdy, out_val, out0, out1, state_out, d_count);
endinterface

// File: rtl/seq_fsm_4s1i2o_stream.sv
// seq_fsm_4s1i2o_stream: 4-state Moore FSM pushing {state,out0,out1} records into a 2-deep FIFO
module seq_fsm_4s1i2o_stream (
  input logic clk,
  input logic reset,
  seq_fsm_4s1i2o_stream_if.slave s
);
  typedef enum logic [1:0] {A = 2'd0, B = 2'd1, C = 2'd2, D = 2'd3} state_t;
  state_t     r_state, w_next;
  logic [1:0] w_mo;
  logic [3:0] r_mem [2];
  logic       r_wp, r_rp;
  logic [1:0] r_cnt;
  logic [7:0] r_dcnt;
  logic       w_acc, w_pop;
  logic [3:0] w_head;
  always_ff @(posedge clk)
    if (reset) r_state <= A;
    else if (w_acc) r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      A: w_next = s.in_ ? B : A;
      B: w_next = s.in_ ? B : C;
      C: w_next = s.in_ ? D : A;
      D: w_next = s.in_ ? B : C;
    endcase
    w_mo = (w_next == D) ? 2'b10 : (w_next == A) ? 2'b00 : 2'b01;
  end
  assign s.in_rdy    = r_cnt != 2'd2;
  assign s.out_val   = r_cnt != 2'd0;
  assign w_acc       = s.in_val && s.in_rdy;
  assign w_pop       = s.out_val && s.out_rdy;
  assign w_head      = s.out_val ? r_mem[r_rp] : 4'd0;
  assign s.state_out = w_head[3:2];
  assign s.out0      = w_head[1];
  assign s.out1      = w_head[0];
  assign s.d_count   = r_dcnt;
  always_ff @(posedge clk)
    if (reset) begin
      r_wp   <= 1'b0;
      r_rp   <= 1'b0;
      r_cnt  <= 2'd0;
      r_dcnt <= 8'd0;
    end else begin
      if (w_acc) begin
        r_mem[r_wp] <= {w_next, w_mo};
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_acc} - {1'b0, w_pop};
      if (w_acc && w_next == D && r_dcnt != 8'hFF) r_dcnt <= r_dcnt + 8'd1;
    end
endmodule

// File: tb/tb_seq_fsm_4s1i2o_stream.sv
// tb_seq_fsm_4s1i2o_stream: random + directed stimulus against a queue-based reference model
module tb_seq_fsm_4s1i2o_stream;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  seq_fsm_4s1i2o_stream_if ifc();
  seq_fsm_4s1i2o_stream dut (.clk(clk), .reset(reset), .s(ifc.slave));
  always #5 clk = ~clk;

  typedef struct {int st; int o0; int o1;} rec_t;
  rec_t q[$];
  int m_state = 0;
  int m_dcnt = 0;
  bit seen_rst = 0;
  int nxt_tbl [4][2] = '{'{0, 1}, '{2, 1}, '{0, 3}, '{2, 1}};
  int moore [4] = '{0, 1, 1, 2};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // monitor/scoreboard: checks the DUT against the model, then advances the model for the coming edge
  always @(negedge clk) begin
    bit acc, pop;
    rec_t r;
    if (seen_rst) begin
      chk("in_rdy", int'(ifc.in_rdy), int'(q.size() < 2));
      chk("out_val", int'(ifc.out_val), int'(q.size() > 0));
      chk("d_count", int'(ifc.d_count), m_dcnt);
      if (q.size() > 0) begin
        chk("state_out", int'(ifc.state_out), q[0].st);
        chk("out0", int'(ifc.out0), q[0].o0);
        chk("out1", int'(ifc.out1), q[0].o1);
      end else
        chk("idle_out", int'({ifc.state_out, ifc.out0, ifc.out1}), 0);
    end
    if (reset) begin
      seen_rst = 1;
      q.delete();
      m_state = 0;
      m_dcnt = 0;
    end else if (seen_rst) begin
      acc = ifc.in_val && q.size() < 2;
      pop = ifc.out_rdy && q.size() > 0;
      if (pop) void'(q.pop_front());
      if (acc) begin
        m_state = nxt_tbl[m_state][ifc.in_];
        r.st = m_state;
        r.o0 = moore[m_state] / 2;
        r.o1 = moore[m_state] % 2;
        q.push_back(r);
        if (m_state == 3 && m_dcnt < 255) m_dcnt++;
      end
    end
  end

  task automatic send(input bit b);
    int n;
    ifc.in_val = 1'b1;
    ifc.in_ = b;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ifc.in_rdy) break;
    end
    if (n == 50) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 ifc.in_val = 1'b0;
  endtask

  task automatic drain();
    int n;
    ifc.out_rdy = 1'b1;
    for (n = 0; n < 20 && q.size() > 0; n++) @(posedge clk);
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    ifc.in_val = 1'b0;
    ifc.in_ = 1'b0;
    ifc.out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ifc.out_rdy = 1'b1;
    send(1); send(0); send(1); send(1);
    drain();
    chk("d_count_seq", int'(ifc.d_count), 1);
    // backpressure: third symbol must wait until out_rdy rises
    do_reset();
    ifc.out_rdy = 1'b0;
    fork
      begin send(1); send(0); send(1); end
      begin repeat (6) @(posedge clk); #1 ifc.out_rdy = 1'b1; end
    join
    drain();
    // saturation
    do_reset();
    send(1);
    for (int i = 0; i < 300; i++) begin send(0); send(1); send(1); end
    drain();
    chk("d_count_sat", int'(ifc.d_count), 255);
    // reset while in D with a full FIFO and a pending symbol
    do_reset();
    send(1);
    drain();
    ifc.out_rdy = 1'b0;
    send(0); send(1);
    ifc.in_val = 1'b1;
    ifc.in_ = 1'b0;
    @(posedge clk);
    #1 do_reset();
    ifc.in_val = 1'b0;
    @(negedge clk);
    chk("rst_out_val", int'(ifc.out_val), 0);
    chk("rst_in_rdy", int'(ifc.in_rdy), 1);
    chk("rst_d_count", int'(ifc.d_count), 0);
    ifc.out_rdy = 1'b1;
    send(1);
    drain();
    // idle periods then random traffic
    for (int k = 0; k < 4; k++) begin
      send(1'($urandom_range(0, 1)));
      repeat (10) @(posedge clk);
      #1 send(1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 2000; i++) begin
      ifc.in_val = 1'($urandom_range(0, 1));
      ifc.in_ = 1'($urandom_range(0, 1));
      ifc.out_rdy = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 199) == 0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    ifc.in_val = 1'b0;
    drain();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
